// File: rtl/t2_pkg.sv
// Shared widths, LFSR tap mask and FSM state encoding for the T2 challenge sequencer.
package t2_pkg;
  localparam int CH_W  = 30;
  localparam int CBM_W = 10;
  // Feedback taps q[29], q[5], q[3], q[0] (x^30 + x^6 + x^4 + x + 1)
  localparam logic [CH_W-1:0] LFSR_TAPS = 30'h2000_0029;

  typedef enum logic [1:0] {IDLE, CLR, SETTLE, EMIT} state_t;
endpackage

// File: rtl/t2_lfsr30.sv
// 30-bit Fibonacci LFSR; advances one step per i_adv pulse.
module t2_lfsr30 import t2_pkg::*; #(
  parameter logic [CH_W-1:0] SEED = 30'h1555_5555
) (
  input  logic            i_clk,
  input  logic            i_clear,
  input  logic            i_adv,
  output logic [CH_W-1:0] o_q
);
  logic [CH_W-1:0] r_q;

  always_ff @(posedge i_clk) begin
    if (i_clear)    r_q <= SEED;
    else if (i_adv) r_q <= {r_q[CH_W-2:0], ^(r_q & LFSR_TAPS)};
  end

  assign o_q = r_q;
endmodule

// File: rtl/t2_challenge_sequencer.sv
// Drives challenges into the T2 array, repeats clear/settle/sample, majority-votes Cbm.
// state  | meaning
// IDLE   | waiting for start; array held cleared
// CLR    | puf_clear high for CLR_CYCLES
// SETTLE | puf_clear low for SETTLE_CYCLES, Cbm sampled on last edge
// EMIT   | voted response offered downstream until accepted
module t2_challenge_sequencer import t2_pkg::*; #(
  parameter int              CLR_CYCLES    = 2,
  parameter int              SETTLE_CYCLES = 8,
  parameter int              EVAL_REPEATS  = 5,
  parameter logic [CH_W-1:0] LFSR_SEED     = 30'h1555_5555
) (
  input  logic             i_clk,
  input  logic             i_clear,
  input  logic             i_start,
  input  logic [15:0]      i_num_challenges,
  output logic [CH_W-1:0]  o_ch_out,
  output logic             o_puf_clear,
  input  logic [CBM_W-1:0] i_cbm_in,
  output logic             o_resp_valid,
  input  logic             i_resp_ready,
  output logic [CBM_W-1:0] o_resp_data,
  output logic [CBM_W-1:0] o_resp_stable,
  output logic [CH_W-1:0]  o_resp_challenge,
  output logic             o_busy,
  output logic             o_done
);
  localparam int CNT_W = $clog2(EVAL_REPEATS + 1);
  localparam int PH_MAX = (CLR_CYCLES > SETTLE_CYCLES) ? CLR_CYCLES : SETTLE_CYCLES;
  localparam int PH_W = $clog2(PH_MAX + 1);

  state_t           r_state, w_state_nxt;
  logic [PH_W-1:0]  r_phase;
  logic [CNT_W-1:0] r_rep;
  logic [15:0]      r_remaining;
  logic [CNT_W-1:0] r_cnt     [CBM_W];
  logic [CNT_W-1:0] w_cnt_nxt [CBM_W];
  logic [CBM_W-1:0] w_vote, w_stable;
  logic [CBM_W-1:0] r_resp_data, r_resp_stable;
  logic [CH_W-1:0]  r_resp_challenge;
  logic             r_done;
  logic             w_phase_end, w_last_rep, w_start, w_sample, w_hs;

  assign w_phase_end = (r_phase == '0);
  assign w_last_rep  = (r_rep == CNT_W'(EVAL_REPEATS - 1));
  assign w_start     = (r_state == IDLE) && i_start;
  assign w_sample    = (r_state == SETTLE) && w_phase_end;
  assign w_hs        = (r_state == EMIT) && i_resp_ready;

  t2_lfsr30 #(.SEED(LFSR_SEED)) u_lfsr (
    .i_clk   (i_clk),
    .i_clear (i_clear),
    .i_adv   (w_hs),
    .o_q     (o_ch_out)
  );

  always_ff @(posedge i_clk) begin
    if (i_clear) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (i_start && i_num_challenges != '0) w_state_nxt = CLR;
      CLR:     if (w_phase_end) w_state_nxt = SETTLE;
      SETTLE:  if (w_phase_end) w_state_nxt = w_last_rep ? EMIT : CLR;
      EMIT:    if (i_resp_ready) w_state_nxt = (r_remaining == 16'd1) ? IDLE : CLR;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Vote on the count including the sample being taken this edge
  always_comb begin
    for (int i = 0; i < CBM_W; i++) begin
      w_cnt_nxt[i] = r_cnt[i] + CNT_W'(i_cbm_in[i]);
      w_vote[i]    = w_cnt_nxt[i] > CNT_W'(EVAL_REPEATS / 2);
      w_stable[i]  = (w_cnt_nxt[i] == '0) || (w_cnt_nxt[i] == CNT_W'(EVAL_REPEATS));
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_clear) begin
      r_phase          <= '0;
      r_rep            <= '0;
      r_remaining      <= '0;
      r_resp_data      <= '0;
      r_resp_stable    <= '0;
      r_resp_challenge <= '0;
      r_done           <= 1'b0;
      for (int i = 0; i < CBM_W; i++) r_cnt[i] <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_state_nxt == CLR && r_state != CLR)            r_phase <= PH_W'(CLR_CYCLES - 1);
      else if (w_state_nxt == SETTLE && r_state != SETTLE) r_phase <= PH_W'(SETTLE_CYCLES - 1);
      else if (!w_phase_end)                               r_phase <= r_phase - 1'b1;

      if (w_start) begin
        r_remaining <= i_num_challenges;
        r_rep       <= '0;
        for (int i = 0; i < CBM_W; i++) r_cnt[i] <= '0;
        if (i_num_challenges == '0) r_done <= 1'b1;
      end

      if (w_sample) begin
        r_rep <= r_rep + 1'b1;
        for (int i = 0; i < CBM_W; i++) r_cnt[i] <= w_cnt_nxt[i];
        if (w_last_rep) begin
          r_resp_data      <= w_vote;
          r_resp_stable    <= w_stable;
          r_resp_challenge <= o_ch_out;
        end
      end

      if (w_hs) begin
        r_remaining <= r_remaining - 1'b1;
        r_rep       <= '0;
        for (int i = 0; i < CBM_W; i++) r_cnt[i] <= '0;
        if (r_remaining == 16'd1) r_done <= 1'b1;
      end
    end
  end

  assign o_puf_clear      = (r_state != SETTLE);
  assign o_busy           = (r_state != IDLE);
  assign o_resp_valid     = (r_state == EMIT);
  assign o_resp_data      = r_resp_data;
  assign o_resp_stable    = r_resp_stable;
  assign o_resp_challenge = r_resp_challenge;
  assign o_done           = r_done;
endmodule

// File: tb/tb_t2_challenge_sequencer.sv
// Scoreboard bench: driver records sampled Cbm values, reference model votes them, monitor compares on handshake.
module tb_t2_challenge_sequencer;
  import t2_pkg::*;

  localparam int CLRC = 2;
  localparam int SETC = 8;
  localparam int REPS = 5;
  localparam logic [29:0] SEED = 30'h1555_5555;

  logic        clk = 1'b0;
  logic        clear = 1'b1;
  logic        start = 1'b0;
  logic        resp_ready = 1'b0;
  logic [15:0] num = '0;
  logic [9:0]  cbm = '0;
  logic [29:0] ch_out, resp_challenge;
  logic [9:0]  resp_data, resp_stable;
  logic        puf_clear, resp_valid, busy, done;

  always #5 clk = ~clk;

  t2_challenge_sequencer #(
    .CLR_CYCLES(CLRC), .SETTLE_CYCLES(SETC), .EVAL_REPEATS(REPS), .LFSR_SEED(SEED)
  ) dut (
    .i_clk(clk), .i_clear(clear), .i_start(start), .i_num_challenges(num),
    .o_ch_out(ch_out), .o_puf_clear(puf_clear), .i_cbm_in(cbm),
    .o_resp_valid(resp_valid), .i_resp_ready(resp_ready), .o_resp_data(resp_data),
    .o_resp_stable(resp_stable), .o_resp_challenge(resp_challenge),
    .o_busy(busy), .o_done(done)
  );

  typedef struct packed {
    logic [9:0]  d;
    logic [9:0]  s;
    logic [29:0] c;
  } exp_t;

  exp_t        exp_q[$];
  logic [9:0]  samples[$];
  logic [29:0] model_ch;
  logic [9:0]  cbm_fixed;
  logic [9:0]  pattern [REPS];
  logic [9:0]  v_s;
  exp_t        e_new, e_pop;
  int          cbm_mode;
  bit          ready_rand;
  int          k;
  int          n_checks = 0;
  int          n_errors = 0;

  function automatic logic [29:0] lfsr_next(input logic [29:0] q);
    return {q[28:0], q[29] ^ q[5] ^ q[3] ^ q[0]};
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  // Driver and reference model: sample edge is the last cycle of each puf_clear-low window
  always @(posedge clk) begin
    #2;
    if (clear) begin
      samples.delete();
      exp_q.delete();
      model_ch = SEED;
      k = 0;
      cbm = 10'($urandom);
    end else begin
      k = puf_clear ? 0 : k + 1;
      if (k == SETC) begin
        case (cbm_mode)
          0:       v_s = cbm_fixed;
          2:       v_s = pattern[samples.size()];
          default: v_s = 10'($urandom);
        endcase
        cbm = v_s;
        samples.push_back(v_s);
        if (samples.size() == REPS) begin
          for (int b = 0; b < 10; b++) begin
            int ones;
            ones = 0;
            for (int j = 0; j < REPS; j++) ones += int'(samples[j][b]);
            e_new.d[b] = (2 * ones > REPS);
            e_new.s[b] = (ones == 0) || (ones == REPS);
          end
          e_new.c = model_ch;
          exp_q.push_back(e_new);
          model_ch = lfsr_next(model_ch);
          samples.delete();
        end
      end else begin
        cbm = (cbm_mode == 0) ? cbm_fixed : 10'($urandom);
      end
    end
    if (ready_rand) resp_ready = 1'($urandom_range(0, 1));
  end

  always @(negedge clk) begin
    if (!clear && resp_valid && resp_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL sb_unexpected: response %0h with no expected entry", resp_data);
      end else begin
        e_pop = exp_q.pop_front();
        chk("sb_data", 64'(resp_data), 64'(e_pop.d));
        chk("sb_stable", 64'(resp_stable), 64'(e_pop.s));
        chk("sb_challenge", 64'(resp_challenge), 64'(e_pop.c));
        chk("sb_ch_out", 64'(ch_out), 64'(e_pop.c));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset();
    chk("rst_ch_out", 64'(ch_out), 64'(SEED));
    chk("rst_puf_clear", 64'(puf_clear), 64'd1);
    chk("rst_valid", 64'(resp_valid), 64'd0);
    chk("rst_data", 64'(resp_data), 64'd0);
    chk("rst_stable", 64'(resp_stable), 64'd0);
    chk("rst_challenge", 64'(resp_challenge), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic do_start(input logic [15:0] n);
    start = 1'b1;
    num = n;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 1;
    while (!resp_valid && cyc < 2000) begin
      tick();
      cyc++;
    end
    if (!resp_valid) chk("valid_timeout", 64'(resp_valid), 64'd1);
  endtask

  task automatic wait_done();
    int c;
    c = 0;
    while (!done && c < 5000) begin
      tick();
      c++;
    end
    chk("done_seen", 64'(done), 64'd1);
  endtask

  task automatic first_scenario();
    int lat;
    cbm_mode = 0;
    cbm_fixed = 10'h2A5;
    resp_ready = 1'b1;
    do_start(16'd1);
    chk("s1_busy", 64'(busy), 64'd1);
    wait_valid(lat);
    chk("s1_latency", 64'(lat), 64'(1 + REPS * (CLRC + SETC)));
    chk("s1_data", 64'(resp_data), 64'h2A5);
    chk("s1_stable", 64'(resp_stable), 64'h3FF);
    chk("s1_challenge", 64'(resp_challenge), 64'(SEED));
    tick();
    chk("s1_done", 64'(done), 64'd1);
    chk("s1_busy_end", 64'(busy), 64'd0);
    chk("s1_valid_end", 64'(resp_valid), 64'd0);
    tick();
    chk("s1_done_pulse", 64'(done), 64'd0);
  endtask

  initial begin
    int lat, falls;
    logic [9:0]  hold_d;
    logic [29:0] hold_c;
    bit prev;
    cbm_mode = 0;
    cbm_fixed = 10'h2A5;
    ready_rand = 0;
    repeat (3) @(posedge clk);
    #1;
    clear = 1'b0;
    check_reset();

    first_scenario();

    // Two challenges back to back
    pulse_clear();
    cbm_mode = 1;
    resp_ready = 1'b1;
    do_start(16'd2);
    wait_done();

    // Bit 0 votes 3 of 5, everything else unanimous zero
    cbm_mode = 2;
    pattern = '{10'h001, 10'h000, 10'h001, 10'h000, 10'h001};
    resp_ready = 1'b0;
    do_start(16'd1);
    wait_valid(lat);
    chk("s3_data", 64'(resp_data), 64'h001);
    chk("s3_stable", 64'(resp_stable), 64'h3FE);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    chk("s3_done", 64'(done), 64'd1);

    // Back-pressure for 20 cycles, with a start attempt while busy
    cbm_mode = 1;
    do_start(16'd1);
    wait_valid(lat);
    hold_d = resp_data;
    hold_c = ch_out;
    for (int i = 0; i < 20; i++) begin
      start = (i == 5);
      num = 16'd3;
      tick();
      chk("stall_valid", 64'(resp_valid), 64'd1);
      chk("stall_data", 64'(resp_data), 64'(hold_d));
      chk("stall_ch_out", 64'(ch_out), 64'(hold_c));
      chk("stall_puf_clear", 64'(puf_clear), 64'd1);
    end
    start = 1'b0;
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    chk("stall_valid_end", 64'(resp_valid), 64'd0);
    chk("stall_done", 64'(done), 64'd1);

    // Zero-length run
    do_start(16'd0);
    chk("zero_done", 64'(done), 64'd1);
    chk("zero_busy", 64'(busy), 64'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("zero_idle", 64'({busy, resp_valid, done}), 64'd0);
    end

    // Clear during the third SETTLE phase
    cbm_mode = 1;
    do_start(16'd1);
    falls = 0;
    prev = 1'b1;
    for (int c = 0; c < 500 && falls < 3; c++) begin
      tick();
      if (prev && !puf_clear) falls++;
      prev = puf_clear;
    end
    chk("mid_third_settle", 64'(falls), 64'd3);
    tick();
    pulse_clear();
    check_reset();
    first_scenario();

    // Random-length runs with random back-pressure
    for (int r = 0; r < 3; r++) begin
      cbm_mode = 1;
      ready_rand = 1;
      do_start(16'($urandom_range(1, 3)));
      wait_done();
      ready_rand = 0;
      resp_ready = 1'b0;
      tick();
    end

    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/t2_challenge_sequencer.md
# t2_challenge_sequencer

Run controller for the T2 multi-PUF challenge-bit array. It generates 30-bit challenges from an LFSR and drives them onto the array's challenge input, pulses the array's clear, and samples the 10-bit Cbm response over several repeated evaluations. It then majority-votes each bit and hands each voted response downstream over a valid/ready interface. It sits directly upstream of the T2 array, owning its C and clear inputs, and consumes its Cbm output.

## Interface
- CLR_CYCLES, 2: cycles puf_clear is held high before each evaluation (≥1)
- SETTLE_CYCLES, 8: cycles puf_clear is held low before each sample (≥1)
- EVAL_REPEATS, 5: evaluations per challenge; must be odd and ≥1
- LFSR_SEED, 30'h15555555: challenge LFSR reset value; must be nonzero
- clk  in  1  sole clock, rising edge
- clear  in  1  synchronous, active-high reset
- start  in  1  begin a run; sampled only in IDLE
- num_challenges  in  16  challenges per run; latched on accepted start
- ch_out  out  30  challenge to the array's C input
- puf_clear  out  1  drives the array's clear input
- cbm_in  in  10  Cbm from the array
- resp_valid  out  1  voted response available
- resp_ready  in  1  downstream accepts the response
- resp_data  out  10  majority-voted Cbm
- resp_stable  out  10  per bit: 1 if all EVAL_REPEATS samples agreed
- resp_challenge  out  30  challenge that produced resp_data
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at end of run

## Operation
- FSM states: IDLE, CLR, SETTLE, EMIT.
- IDLE:
  - On start=1, latch num_challenges into remaining and clear the vote counters.
  - If the latched value is 0, pulse done next cycle and stay in IDLE.
  - Otherwise go to CLR.
- CLR:
  - puf_clear=1 for CLR_CYCLES cycles, then go to SETTLE.
- SETTLE:
  - puf_clear=0 for SETTLE_CYCLES cycles.
  - On the edge ending the last SETTLE cycle, sample cbm_in and add each bit into a per-bit ones counter (width clog2(EVAL_REPEATS+1)).
  - If fewer than EVAL_REPEATS samples have been taken, return to CLR.
  - Otherwise go to EMIT, loading resp_data[i] = (count[i] > EVAL_REPEATS/2), resp_stable[i] = (count[i]==0 or count[i]==EVAL_REPEATS), and resp_challenge = ch_out.
- EMIT:
  - resp_valid=1. resp_data, resp_stable and resp_challenge are held constant until the handshake.
  - On resp_valid & resp_ready: advance the LFSR, decrement remaining, clear the counters.
  - If remaining becomes 0, go to IDLE and pulse done; otherwise go to CLR.
- puf_clear=1 in every state except SETTLE, so the array stays cleared while idle or back-pressured.
- LFSR:
  - 30-bit Fibonacci, polynomial x^30+x^6+x^4+x+1.
  - fb = q[29]^q[5]^q[3]^q[0]; next = {q[28:0], fb}.
  - ch_out = q. It changes only on a response handshake or reset.
  - The LFSR is not reseeded by start; runs continue the sequence.
- start while busy is ignored. resp_ready while resp_valid=0 is ignored. cbm_in outside the sample edge is ignored.
- clear (any state, mid-run included) returns all state to reset values in the next cycle. Partial votes are discarded.

## Timing
- Reset values:
  - ch_out=LFSR_SEED
  - puf_clear=1
  - resp_valid=0, resp_data=0, resp_stable=0, resp_challenge=0
  - busy=0, done=0
  - FSM state IDLE
- start accepted at edge t: CLR begins in cycle t+1, busy=1 from t+1.
- First resp_valid in cycle t+1+EVAL_REPEATS×(CLR_CYCLES+SETTLE_CYCLES); with defaults, t+51.
- Handshake at edge h, not last: new ch_out visible in cycle h+1, CLR begins h+1; next resp_valid at h+1+EVAL_REPEATS×(CLR_CYCLES+SETTLE_CYCLES).
- Handshake at edge h, last: resp_valid=0, done=1 and busy=0 in cycle h+1; done=0 in h+2.
- num_challenges=0: done=1 in cycle t+1, busy stays 0.
- resp_valid never deasserts without a handshake, except on clear.

## Structure
- Package t2_pkg holds:
  - CH_W=30, CBM_W=10
  - LFSR tap constant
  - FSM state enum (IDLE, CLR, SETTLE, EMIT)
- Sub-module t2_lfsr30: ports clk, clear, adv, q[29:0]; parameter SEED. Also reusable for other techniques.
- Vote counters, phase counter, repeat counter and remaining counter stay in the top module.

## Test plan
- Reset, then start with num_challenges=1 and cbm_in held at 10'h2A5 (default parameters): resp_valid rises exactly 51 cycles after start; resp_data=10'h2A5, resp_stable=10'h3FF, resp_challenge=30'h15555555; done pulses once after the handshake.
- num_challenges=2, resp_ready=1: second resp_challenge=30'h2AAAAAAB; ch_out changes only at the handshake edge.
- Drive cbm_in[0]=1 on samples 1, 3, 5 and 0 on samples 2, 4, other bits 0: resp_data=10'h001, resp_stable=10'h3FE.
- Hold resp_ready=0 for 20 cycles in EMIT: resp_valid, resp_data and ch_out stay constant, puf_clear=1 throughout; a single ready cycle completes the transfer.
- start with num_challenges=0: done=1 one cycle later, busy stays 0, no resp_valid.
- Assert clear during the third SETTLE phase: next cycle all outputs are at reset values and ch_out=30'h15555555; a fresh start behaves as in the first scenario.
